// File: rtl/alu_arbiter.sv
// alu_arbiter
//
// Purpose:
//   Shares one registered ALU between two requesters. A round-robin arbiter
//   accepts one request at a time, latches its opcode and operands, pulses
//   the ALU load strobe, captures the ALU result one cycle later and returns
//   it to the requester that was accepted. A new request is not accepted
//   until that response has been handed back.
//
// Optional feature (macro ALU_ARB_OPCODE_CHECK_EN):
//   When defined, opcodes 14 and 15 are treated as illegal. They are never
//   sent to the ALU. The block answers straight away with resp_err = 1 and
//   resp_out, resp_ovf and resp_unf all 0. When not defined, every opcode
//   goes to the ALU and resp_err is always 0.
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   req_valid[1:0]              request strobe, bit n = requester n
//   req_ready[1:0]              one-hot accept to the granted requester
//   req0_opcode/a/b             requester 0 opcode and operands
//   req1_opcode/a/b             requester 1 opcode and operands
//   resp_valid[1:0]             one-hot response strobe to the owner
//   resp_ready[1:0]             per-requester response accept
//   resp_out                    captured result (shared bus)
//   resp_ovf/resp_unf/resp_err  captured overflow, underflow, illegal-opcode
//   alu_opcode, alu_a, alu_b    latched ALU inputs
//   alu_set                     ALU load strobe (one cycle per operation)
//   alu_out, alu_overflow,      registered ALU outputs
//   alu_underflow
//   busy                        high whenever the FSM is not idle

module alu_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req0_opcode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req1_opcode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_out,
  output logic             resp_ovf,
  output logic             resp_unf,
  output logic             resp_err,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_set,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_overflow,
  input  logic             alu_underflow,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic             last_grant;
  logic             owner;
  logic             grant_id;
  logic             accept;
  logic             illegal_op;
  logic             resp_err_q;
  logic [3:0]       sel_opcode;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // Round-robin choice. A single valid requester always wins. On a tie,
  // the requester that was not served last wins.
  always_comb begin
    grant_id = 1'b0;
    case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

  // req_ready is only offered in IDLE. It is also held low while reset is
  // asserted, so a handshake can never appear to happen in a reset cycle.
  assign req_ready = (state == IDLE && !reset && (|req_valid))
                     ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign accept    = |(req_valid & req_ready);

  assign sel_opcode = grant_id ? req1_opcode : req0_opcode;
  assign sel_a      = grant_id ? req1_a      : req0_a;
  assign sel_b      = grant_id ? req1_b      : req0_b;

`ifdef ALU_ARB_OPCODE_CHECK_EN
  assign illegal_op = (sel_opcode[3:1] == 3'b111);
`else
  assign illegal_op = 1'b0;
`endif

  // Next-state logic. An illegal opcode (only possible when the check is
  // enabled) skips the ALU and goes straight to RESP. RESP only listens to
  // the ready bit of the requester that owns the response.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = illegal_op ? RESP : ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    next_state = RESP;
      RESP:    if (resp_ready[owner]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, arbitration pointer, latched request and response registers.
  // On acceptance the request is latched into the ALU input registers, and
  // they keep that value until the next acceptance. In WAIT the ALU result
  // is already registered, so it is copied into the response registers.
  // An illegal opcode loads the error response at acceptance instead.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      resp_out   <= '0;
      resp_ovf   <= 1'b0;
      resp_unf   <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        last_grant <= grant_id;
        owner      <= grant_id;
        alu_opcode <= sel_opcode;
        alu_a      <= sel_a;
        alu_b      <= sel_b;
        if (illegal_op) begin
          resp_out   <= '0;
          resp_ovf   <= 1'b0;
          resp_unf   <= 1'b0;
          resp_err_q <= 1'b1;
        end
      end
      if (state == WAIT) begin
        resp_out   <= alu_out;
        resp_ovf   <= alu_overflow;
        resp_unf   <= alu_underflow;
        resp_err_q <= 1'b0;
      end
    end
  end

  assign resp_err   = resp_err_q;
  assign alu_set    = (state == ISSUE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//
// Purpose:
//   Self-checking bench for alu_arbiter with WIDTH = 4. A small registered
//   ALU model is attached. The bench runs a table of directed transactions,
//   then hand-written sequences for round-robin, response stall, reset
//   abort and opcode 15, then randomized transactions that are checked
//   against an integer reference model.
//   The macro ALU_ARB_OPCODE_CHECK_EN selects which opcode-15 result is
//   expected.

module tb_alu_arbiter;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [3:0]       req0_opcode = '0;
  logic [3:0]       req0_a = '0;
  logic [3:0]       req0_b = '0;
  logic [3:0]       req1_opcode = '0;
  logic [3:0]       req1_a = '0;
  logic [3:0]       req1_b = '0;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready = '0;
  logic [3:0]       resp_out;
  logic             resp_ovf;
  logic             resp_unf;
  logic             resp_err;
  logic [3:0]       alu_opcode;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic             alu_set;
  logic [3:0]       alu_out = '0;
  logic             alu_overflow = 1'b0;
  logic             alu_underflow = 1'b0;
  logic             busy;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_opcode(req0_opcode), .req0_a(req0_a), .req0_b(req0_b),
    .req1_opcode(req1_opcode), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_out(resp_out), .resp_ovf(resp_ovf), .resp_unf(resp_unf),
    .resp_err(resp_err),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_set(alu_set),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .alu_underflow(alu_underflow),
    .busy(busy)
  );

  // Registered ALU model. It loads its result on the clock edge where
  // alu_set is high.
  always @(posedge clk) begin
    if (alu_set) begin
      alu_overflow  <= 1'b0;
      alu_underflow <= 1'b0;
      case (alu_opcode)
        4'd0: {alu_overflow, alu_out} <= {1'b0, alu_a} + {1'b0, alu_b};
        4'd1: begin
          alu_out       <= alu_a - alu_b;
          alu_underflow <= (alu_a < alu_b);
        end
        4'd2:    alu_out <= alu_a & alu_b;
        4'd3:    alu_out <= alu_a | alu_b;
        4'd4:    alu_out <= alu_a ^ alu_b;
        default: alu_out <= 4'd0;
      endcase
    end
  end

  // Integer reference for the ALU result, computed with plain arithmetic.
  function automatic void refAlu(input int op, input int a, input int b,
                                 output int out, output int ovf, output int unf);
    int s;
    ovf = 0;
    unf = 0;
    out = 0;
    case (op)
      0: begin s = a + b; out = s % 16; ovf = (s > 15) ? 1 : 0; end
      1: begin s = a - b; unf = (s < 0) ? 1 : 0; out = (s < 0) ? s + 16 : s; end
      2: out = a & b;
      3: out = a | b;
      4: out = a ^ b;
      default: out = 0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  typedef struct {
    int         grant;
    int         set_k;
    int         set_count;
    int         resp_k;
    logic [1:0] resp_mask;
    logic [3:0] out;
    logic       ovf;
    logic       unf;
    logic       err;
    int         unstable;
    int         hold_bad;
    bit         idle_after;
    bit         timeout;
  } obs_t;

  typedef struct {
    logic [1:0] valid;
    logic [3:0] op0, a0, b0, op1, a1, b1;
    int         exp_grant;
    int         exp_out, exp_ovf, exp_unf;
  } vec_t;

  // Runs one transaction. It is called just after a falling edge. It records
  // the grant, the cycle (relative to acceptance) of alu_set and resp_valid,
  // and the response. It stalls resp_ready for 'stall' RESP cycles, during
  // which only the non-owner bit is driven. It checks that the FSM is back
  // in IDLE on the cycle after the handshake.
  task automatic applyStimulus(input logic [1:0] valid,
                               input logic [3:0] op0, input logic [3:0] a0, input logic [3:0] b0,
                               input logic [3:0] op1, input logic [3:0] a1, input logic [3:0] b1,
                               input int stall, input bit keep_valid, output obs_t o);
    int n;
    int stall_left;
    bit handshake;
    logic [3:0] exp_op, exp_a, exp_b;
    o.grant = -1; o.set_k = -1; o.set_count = 0; o.resp_k = -1;
    o.resp_mask = '0; o.out = '0; o.ovf = 0; o.unf = 0; o.err = 0;
    o.unstable = 0; o.hold_bad = 0; o.idle_after = 0; o.timeout = 0;
    req_valid = valid;
    req0_opcode = op0; req0_a = a0; req0_b = b0;
    req1_opcode = op1; req1_a = a1; req1_b = b1;
    resp_ready = 2'b00;
    #1;
    n = 0;
    while (!(|(req_valid & req_ready)) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!(|(req_valid & req_ready))) begin
      o.timeout = 1;
      req_valid = 2'b00;
      return;
    end
    o.grant = req_ready[1] ? 1 : 0;
    exp_op = o.grant == 1 ? op1 : op0;
    exp_a  = o.grant == 1 ? a1  : a0;
    exp_b  = o.grant == 1 ? b1  : b0;
    stall_left = stall;
    handshake = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!keep_valid) req_valid = 2'b00;
      if (handshake) begin
        o.idle_after = (busy == 1'b0 && resp_valid == 2'b00);
        break;
      end
      if (alu_set) begin
        o.set_count++;
        if (o.set_k < 0) o.set_k = k;
      end
      if (busy && (alu_opcode !== exp_op || alu_a !== exp_a || alu_b !== exp_b))
        o.hold_bad++;
      if (resp_valid != 2'b00) begin
        if (o.resp_k < 0) begin
          o.resp_k = k; o.resp_mask = resp_valid; o.out = resp_out;
          o.ovf = resp_ovf; o.unf = resp_unf; o.err = resp_err;
        end else if (resp_valid !== o.resp_mask || resp_out !== o.out ||
                     resp_ovf !== o.ovf || resp_unf !== o.unf ||
                     resp_err !== o.err || req_ready !== 2'b00 || busy !== 1'b1) begin
          o.unstable++;
        end
        if (stall_left == 0) begin
          resp_ready = 2'b11;
          handshake = 1;
        end else begin
          stall_left--;
          resp_ready = ~o.resp_mask;
        end
      end
    end
    if (!o.idle_after) o.timeout = 1;
    resp_ready = 2'b00;
  endtask

  // Checks a transaction that took the normal ALU path.
  task automatic checkTxn(input string tag, input obs_t o, input int exp_grant,
                          input int exp_out, input int exp_ovf, input int exp_unf);
    checkOutput({tag, " timeout"}, int'(o.timeout), 0);
    checkOutput({tag, " grant"}, o.grant, exp_grant);
    checkOutput({tag, " resp_valid"}, int'(o.resp_mask), (exp_grant == 1) ? 2 : 1);
    checkOutput({tag, " alu_set cycle"}, o.set_k, 1);
    checkOutput({tag, " alu_set count"}, o.set_count, 1);
    checkOutput({tag, " resp cycle"}, o.resp_k, 3);
    checkOutput({tag, " resp_out"}, int'(o.out), exp_out);
    checkOutput({tag, " resp_ovf"}, int'(o.ovf), exp_ovf);
    checkOutput({tag, " resp_unf"}, int'(o.unf), exp_unf);
    checkOutput({tag, " resp_err"}, int'(o.err), 0);
    checkOutput({tag, " alu hold"}, o.hold_bad, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = 2'b00;
    resp_ready = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t  vecs[10];
    obs_t  o;
    int    last_served;
    int    seen;
    int    eo, ev, eu, eg;
    logic [1:0] rv;
    logic [3:0] r_op0, r_a0, r_b0, r_op1, r_a1, r_b1;
    int    r_stall;

    // Directed vectors, run in order after reset (the grant pointer starts at 1).
    vecs[0] = '{2'b01, 4'd0, 4'd9,  4'd8,  4'd0, 4'd0,  4'd0,  0, 1,  1, 0};
    vecs[1] = '{2'b10, 4'd0, 4'd0,  4'd0,  4'd1, 4'd3,  4'd5,  1, 14, 0, 1};
    vecs[2] = '{2'b11, 4'd0, 4'd2,  4'd3,  4'd4, 4'd6,  4'd1,  0, 5,  0, 0};
    vecs[3] = '{2'b11, 4'd3, 4'd1,  4'd2,  4'd1, 4'd7,  4'd7,  1, 0,  0, 0};
    vecs[4] = '{2'b01, 4'd2, 4'd12, 4'd10, 4'd0, 4'd0,  4'd0,  0, 8,  0, 0};
    vecs[5] = '{2'b10, 4'd0, 4'd0,  4'd0,  4'd3, 4'd5,  4'd2,  1, 7,  0, 0};
    vecs[6] = '{2'b10, 4'd0, 4'd0,  4'd0,  4'd4, 4'd15, 4'd15, 1, 0,  0, 0};
    vecs[7] = '{2'b01, 4'd0, 4'd15, 4'd1,  4'd0, 4'd0,  4'd0,  0, 0,  1, 0};
    vecs[8] = '{2'b01, 4'd1, 4'd0,  4'd1,  4'd0, 4'd0,  4'd0,  0, 15, 0, 1};
    vecs[9] = '{2'b11, 4'd2, 4'd3,  4'd3,  4'd0, 4'd8,  4'd8,  1, 0,  1, 0};

    // Reset values, with both requests held high during reset.
    reset = 1'b1;
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    checkOutput("reset req_ready", int'(req_ready), 0);
    checkOutput("reset resp_valid", int'(resp_valid), 0);
    checkOutput("reset resp_out", int'(resp_out), 0);
    checkOutput("reset resp_ovf", int'(resp_ovf), 0);
    checkOutput("reset resp_unf", int'(resp_unf), 0);
    checkOutput("reset resp_err", int'(resp_err), 0);
    checkOutput("reset alu_set", int'(alu_set), 0);
    checkOutput("reset alu_opcode", int'(alu_opcode), 0);
    checkOutput("reset alu_a", int'(alu_a), 0);
    checkOutput("reset alu_b", int'(alu_b), 0);
    checkOutput("reset busy", int'(busy), 0);
    req_valid = 2'b00;
    reset = 1'b0;

    // Table-driven transactions.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].op0, vecs[i].a0, vecs[i].b0,
                    vecs[i].op1, vecs[i].a1, vecs[i].b1, 0, 1'b0, o);
      checkTxn($sformatf("vec%0d", i), o, vecs[i].exp_grant,
               vecs[i].exp_out, vecs[i].exp_ovf, vecs[i].exp_unf);
      checkOutput($sformatf("vec%0d idle after", i), int'(o.idle_after), 1);
    end

    // Both requesters valid all the time: grants alternate 0,1,0,1.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b11, 4'd0, 4'(i), 4'd1, 4'd1, 4'(i + 5), 4'd2, 0, 1'b1, o);
      if (i % 2 == 0) refAlu(0, i, 1, eo, ev, eu);
      else            refAlu(1, i + 5, 2, eo, ev, eu);
      checkTxn($sformatf("rr%0d", i), o, i % 2, eo, ev, eu);
    end
    req_valid = 2'b00;

    // Response stalled for 5 cycles, with only the non-owner ready bit driven.
    doReset();
    applyStimulus(2'b10, 4'd0, 4'd0, 4'd0, 4'd0, 4'd6, 4'd7, 5, 1'b0, o);
    checkTxn("stall", o, 1, 13, 0, 0);
    checkOutput("stall stability", o.unstable, 0);
    checkOutput("stall idle after release", int'(o.idle_after), 1);

    // Reset asserted in WAIT aborts the request with no response.
    doReset();
    req_valid = 2'b01; req0_opcode = 4'd0; req0_a = 4'd9; req0_b = 4'd8;
    #1;
    checkOutput("abort accept", int'(req_ready), 1);
    @(negedge clk);
    req_valid = 2'b00;
    checkOutput("abort issue alu_set", int'(alu_set), 1);
    @(negedge clk);
    checkOutput("abort wait busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort resp_valid", int'(resp_valid), 0);
    checkOutput("abort alu_set", int'(alu_set), 0);
    reset = 1'b0;
    resp_ready = 2'b11;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid != 2'b00) seen++;
    end
    checkOutput("abort no response", seen, 0);
    resp_ready = 2'b00;

    // Opcode 15.
    doReset();
    applyStimulus(2'b01, 4'd15, 4'd3, 4'd4, 4'd0, 4'd0, 4'd0, 0, 1'b0, o);
    checkOutput("op15 timeout", int'(o.timeout), 0);
    checkOutput("op15 resp_valid", int'(o.resp_mask), 1);
`ifdef ALU_ARB_OPCODE_CHECK_EN
    checkOutput("op15 alu_set count", o.set_count, 0);
    checkOutput("op15 resp cycle", o.resp_k, 1);
    checkOutput("op15 resp_err", int'(o.err), 1);
    checkOutput("op15 resp_out", int'(o.out), 0);
    checkOutput("op15 resp_ovf", int'(o.ovf), 0);
    checkOutput("op15 resp_unf", int'(o.unf), 0);
`else
    checkOutput("op15 alu_set cycle", o.set_k, 1);
    checkOutput("op15 alu_set count", o.set_count, 1);
    checkOutput("op15 resp cycle", o.resp_k, 3);
    checkOutput("op15 resp_err", int'(o.err), 0);
`endif

    // Randomized transactions against the reference model.
    doReset();
    last_served = 1;
    for (int i = 0; i < 40; i++) begin
      rv = 2'($urandom_range(1, 3));
      r_op0 = 4'($urandom_range(0, 13)); r_a0 = 4'($urandom); r_b0 = 4'($urandom);
      r_op1 = 4'($urandom_range(0, 13)); r_a1 = 4'($urandom); r_b1 = 4'($urandom);
      r_stall = int'($urandom_range(0, 2));
      applyStimulus(rv, r_op0, r_a0, r_b0, r_op1, r_a1, r_b1, r_stall, 1'b0, o);
      if (rv == 2'b11) eg = 1 - last_served;
      else             eg = (rv == 2'b10) ? 1 : 0;
      last_served = eg;
      if (eg == 1) refAlu(int'(r_op1), int'(r_a1), int'(r_b1), eo, ev, eu);
      else         refAlu(int'(r_op0), int'(r_a0), int'(r_b0), eo, ev, eu);
      checkTxn($sformatf("rand%0d", i), o, eg, eo, ev, eu);
      checkOutput($sformatf("rand%0d stability", i), o.unstable, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: operand/result width; SHALL match the attached ALU.
REQ-002 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester request strobe; bit n = requester n.
REQ-005 req_ready  output  2  per-requester accept; request n accepted on a cycle with req_valid[n] && req_ready[n].
REQ-006 req0_opcode / req1_opcode  input  4 each  requested ALU opcode.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  WIDTH each  requested operands.
REQ-008 resp_valid  output  2  one-hot response strobe to owning requester.
REQ-009 resp_ready  input  2  per-requester response accept.
REQ-010 resp_out  output  WIDTH  shared result bus; meaningful only while resp_valid != 0.
REQ-011 resp_ovf / resp_unf / resp_err  output  1 each  captured overflow, underflow, illegal-opcode flags.
REQ-012 alu_opcode  output  4; alu_a, alu_b  output  WIDTH  drive the ALU inputs.
REQ-013 alu_set  output  1  ALU load strobe.
REQ-014 alu_out  input  WIDTH; alu_overflow, alu_underflow  input  1  registered ALU outputs.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one transition per cycle.
REQ-017 IDLE: req_ready SHALL be one-hot to the granted requester (combinational from req_valid); with no req_valid set, req_ready = 0 and the FSM stays in IDLE.
REQ-018 Arbitration SHALL be round-robin: if only one requester is valid, grant it; if both are valid, grant the one not granted last. The last-grant pointer SHALL update only on acceptance.
REQ-019 On acceptance the block SHALL latch the requester id, opcode, A, and B, then go to ISSUE.
REQ-020 ISSUE: alu_set = 1 for exactly one cycle, with the latched opcode/A/B on alu_*; then go to WAIT.
REQ-021 WAIT: alu_set = 0. Capture alu_out, alu_overflow, and alu_underflow into the response registers, with resp_err = 0. Then go to RESP.
REQ-022 RESP: resp_valid[id] = 1 with stable resp_* values until resp_ready[id] = 1. Go to IDLE on the cycle after the handshake.
REQ-023 Latency: acceptance at cycle T gives alu_set at T+1, capture at T+2, and resp_valid at T+3 (minimum 4 cycles per operation). There SHALL be no back-to-back overlap.
REQ-024 alu_opcode/alu_a/alu_b SHALL hold their latched values from ISSUE through RESP. alu_set SHALL never be high outside ISSUE.
REQ-025 req_ready SHALL be 0 in ISSUE, WAIT, and RESP; requests arriving then wait.
REQ-026 The response SHALL go only to the accepted requester; resp_ready on the other bit SHALL be ignored.

Reset
REQ-027 On reset the block SHALL enter IDLE.
REQ-028 On reset the outputs SHALL be: req_ready = 0, resp_valid = 0, resp_out = 0, resp_ovf = resp_unf = resp_err = 0, alu_set = 0, alu_opcode = 0, alu_a = alu_b = 0, busy = 0.
REQ-029 On reset the last-grant pointer SHALL be 1, so requester 0 wins the first tie.
REQ-030 Reset in any state SHALL abort the transaction with no response, and reset SHALL take priority over all handshakes in that cycle.

Configuration
REQ-031 Macro ALU_ARB_OPCODE_CHECK_EN, when defined: an accepted opcode of 14 or 15 SHALL skip ISSUE and WAIT, with no alu_set.
REQ-032 With ALU_ARB_OPCODE_CHECK_EN defined, the FSM SHALL go from IDLE directly to RESP with resp_err = 1, resp_out = 0, and resp_ovf = resp_unf = 0, so resp_valid is at T+1.
REQ-033 Without ALU_ARB_OPCODE_CHECK_EN: all 16 opcodes SHALL take the normal path, resp_err SHALL be constant 0, and the value of resp_out for opcodes 14/15 is undefined.

Verification (WIDTH=4; the ALU model registers on set, opcodes 0=ADD, 1=SUB)
REQ-034 Requester 0 ADD, A=9, B=8, resp_ready=1 -> alu_set at T+1; resp_valid=01 at T+3 with resp_out=1, resp_ovf=1, resp_unf=0.
REQ-035 Requester 1 SUB, A=3, B=5 -> resp_valid=10 at T+3 with resp_out=14, resp_unf=1, resp_ovf=0.
REQ-036 After reset, both requesters valid continuously -> grants alternate 0,1,0,1; each response goes to the matching bit.
REQ-037 resp_ready held 0 for 5 cycles in RESP -> resp_valid and resp_out stay stable, req_ready stays 00, and busy=1; release -> IDLE next cycle.
REQ-038 Reset asserted in WAIT -> the next cycle shows busy=0, resp_valid=00, alu_set=0, and no response is ever issued for the aborted request.
REQ-039 With ALU_ARB_OPCODE_CHECK_EN, opcode 15 -> alu_set never asserted and resp_err=1 at T+1; without the macro -> alu_set at T+1 and resp_err=0.
